processor_datapath: RTL and testbench
=====================================

Name: processor_datapath

Overview:
- Execution datapath directly downstream of the processor control state machine.
- Consumes that FSM's per-state control outputs: D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr and Alu_s0.
- Contains a 16-entry register file, a 3-bit-select ALU and a 256-word data memory with one-cycle read latency. The control FSM's two-cycle Load_A/Load_B sequence exists to cover that latency.
- Exposes operand, ALU and memory values for top-level display and verification.

Parameters:
- DATA_W, 16, width of registers, ALU and data memory words.
- RF_AW, 4, register file address width (2**RF_AW registers).
- DM_AW, 8, data memory address width (2**DM_AW words).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- D_addr  input  DM_AW  data memory address.
- D_wr  input  1  data memory write enable.
- RF_s  input  1  register write-data select: 1 = data memory read data, 0 = ALU result.
- RF_W_en  input  1  register file write enable.
- RF_W_addr  input  RF_AW  register file write address.
- RF_Ra_addr  input  RF_AW  A-side read address.
- RF_Rb_addr  input  RF_AW  B-side read address.
- Alu_s0  input  3  ALU function select.
- Ra_data  output  DATA_W  A-side read data.
- Rb_data  output  DATA_W  B-side read data.
- Alu_out  output  DATA_W  ALU result.
- Alu_zero  output  1  high when Alu_out == 0.
- Dm_rdata  output  DATA_W  registered data memory read data.
- W_data  output  DATA_W  register file write-data mux output.

Behaviour:
- Reset (ResetN low, asynchronous):
  - All 16 registers clear to 0. Dm_rdata clears to 0.
  - Data memory contents are not cleared.
  - While in reset: Ra_data = Rb_data = 0, Alu_out follows combinational rules on the zeroed registers, Alu_zero = 1 for ops 0–6.
  - Writes are blocked while ResetN is low.
  - Deasserting reset mid-sequence (e.g. between Load_A and Load_B) leaves registers zero. No pending write survives.
- Register file:
  - Reads are combinational: Ra_data = R[RF_Ra_addr], Rb_data = R[RF_Rb_addr].
  - Write at rising edge when RF_W_en = 1: R[RF_W_addr] <= W_data.
  - Same-cycle read of the register being written returns the old value; the new value is visible after the edge.
  - Register 0 is an ordinary writable register.
- Write mux: W_data = RF_s ? Dm_rdata : Alu_out.
- ALU (combinational, all arithmetic modulo 2**DATA_W, no carry/overflow output), A = Ra_data, B = Rb_data:
  - 0: 0
  - 1: A + B
  - 2: A − B
  - 3: A
  - 4: A ^ B
  - 5: A | B
  - 6: A & B
  - 7: A + 1
- Data memory:
  - 2**DM_AW × DATA_W, synchronous.
  - Each rising edge: Dm_rdata <= mem[D_addr], unconditionally, one-cycle latency.
  - When D_wr = 1 at the same edge: mem[D_addr] <= Ra_data (store source is always the A-side register).
  - Read-during-write to the same address returns the OLD word in Dm_rdata; the new word is visible on the next read.
  - D_addr wraps naturally within DM_AW bits.
- Load sequence from the control FSM:
  - Cycle N (Load_A): D_addr stable, RF_s = 1, RF_W_en = 0. The edge at the end of N captures mem[D_addr] into Dm_rdata.
  - Cycle N+1 (Load_B): same D_addr, RF_s = 1, RF_W_en = 1. The edge at the end of N+1 writes Dm_rdata into R[RF_W_addr].
- Store: a single cycle with D_wr = 1 and RF_Ra_addr = source register.
- Add/Sub: a single cycle with RF_s = 0 and RF_W_en = 1. Result is written at the end-of-cycle edge.
- Simultaneous D_wr and RF_W_en are both honoured independently, in the same edge.
- No internal FSM. All sequencing comes from the control unit; this block must behave correctly for any input combination each cycle.

Test Plan:
- Reset: hold ResetN = 0 for 2 cycles, then read all 16 addresses -> every Ra_data/Rb_data = 16'h0000 and Dm_rdata = 0. Assert ResetN low asynchronously mid-cycle -> outputs zero without waiting for Clk.
- Load: preload mem[8'h1A] = 16'h00F3 via a store. Run Load_A (D_addr = 1A, RF_s = 1, RF_W_addr = 3), then Load_B with RF_W_en = 1 -> after Load_B edge R3 = 16'h00F3. R3 unchanged after Load_A alone.
- Add/Sub wrap: R1 = 16'hFFFF, R2 = 16'h0002. Alu_s0 = 1, Ra = 1, Rb = 2, W = 4 -> R4 = 16'h0001. Alu_s0 = 2, Ra = 2, Rb = 1, W = 5 -> R5 = 16'h0003. Alu_s0 = 2, Ra = Rb = 1 -> Alu_out = 0 and Alu_zero = 1.
- Store: R6 = 16'hBEEF, D_wr = 1, D_addr = 8'hFF, RF_Ra_addr = 6 -> next-cycle read of FF gives Dm_rdata = 16'hBEEF. Same-edge read of FF returns the prior contents.
- Read-during-write in register file: RF_W_en = 1, W_addr = 7, Ra = 7, R7 = 16'h0010, op 7 -> Ra_data = 16'h0010 before the edge, 16'h0011 after.
- Reset between Load_A and Load_B: pulse ResetN low -> the target register stays 0 and Dm_rdata = 0.

Source files
------------

// File: rtl/processor_datapath_if.sv
// processor_datapath_if
// Bundles the control-FSM-to-datapath signals and the observed datapath values.
//   master : control side, drives the per-state controls and reads the results
//   slave  : datapath side, consumes the controls and drives the results
// Controls : D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0
// Results  : Ra_data, Rb_data, Alu_out, Alu_zero, Dm_rdata, W_data
interface processor_datapath_if #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
);
  logic [DM_AW-1:0]  D_addr;
  logic              D_wr;
  logic              RF_s;
  logic              RF_W_en;
  logic [RF_AW-1:0]  RF_W_addr;
  logic [RF_AW-1:0]  RF_Ra_addr;
  logic [RF_AW-1:0]  RF_Rb_addr;
  logic [2:0]        Alu_s0;

  logic [DATA_W-1:0] Ra_data;
  logic [DATA_W-1:0] Rb_data;
  logic [DATA_W-1:0] Alu_out;
  logic              Alu_zero;
  logic [DATA_W-1:0] Dm_rdata;
  logic [DATA_W-1:0] W_data;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    input  Ra_data, Rb_data, Alu_out, Alu_zero, Dm_rdata, W_data
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    output Ra_data, Rb_data, Alu_out, Alu_zero, Dm_rdata, W_data
  );
endinterface

// File: rtl/processor_datapath.sv
// processor_datapath
// Execution datapath under the processor control FSM: 2**RF_AW-entry register
// file with two combinational read ports, a 3-bit-select ALU, and a 2**DM_AW-word
// data memory with one-cycle registered read.
// Ports:
//   Clk    : system clock, all state updates on the rising edge
//   ResetN : asynchronous active-low reset (clears registers and Dm_rdata only)
//   dp     : processor_datapath_if.slave carrying the controls and results
module processor_datapath #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
) (
  input  logic                Clk,
  input  logic                ResetN,
  processor_datapath_if.slave dp
);

  logic [DATA_W-1:0] reg_file [2**RF_AW];
  logic [DATA_W-1:0] data_mem [2**DM_AW];
  logic [DATA_W-1:0] ra_value;
  logic [DATA_W-1:0] rb_value;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [DATA_W-1:0] w_data;

  // Combinational read ports; a same-cycle write is only seen after the edge.
  assign ra_value = reg_file[dp.RF_Ra_addr];
  assign rb_value = reg_file[dp.RF_Rb_addr];

  // ALU, everything wraps modulo 2**DATA_W.
  always_comb begin
    alu_result = '0;
    case (dp.Alu_s0)
      3'd0:    alu_result = '0;
      3'd1:    alu_result = ra_value + rb_value;
      3'd2:    alu_result = ra_value - rb_value;
      3'd3:    alu_result = ra_value;
      3'd4:    alu_result = ra_value ^ rb_value;
      3'd5:    alu_result = ra_value | rb_value;
      3'd6:    alu_result = ra_value & rb_value;
      default: alu_result = ra_value + DATA_W'(1);
    endcase
  end

  assign w_data = dp.RF_s ? dm_rdata_q : alu_result;

  // Register file; reset clears every entry, including register 0.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 2**RF_AW; i++) reg_file[i] <= '0;
    end else if (dp.RF_W_en) begin
      reg_file[dp.RF_W_addr] <= w_data;
    end
  end

  // Data memory array keeps its contents through reset, but stores are
  // suppressed while reset is held so nothing lands during a reset pulse.
  always_ff @(posedge Clk) begin
    if (ResetN && dp.D_wr) data_mem[dp.D_addr] <= ra_value;
  end

  // Read register samples unconditionally, so read-during-write yields the old word.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) dm_rdata_q <= '0;
    else         dm_rdata_q <= data_mem[dp.D_addr];
  end

  assign dp.Ra_data  = ra_value;
  assign dp.Rb_data  = rb_value;
  assign dp.Alu_out  = alu_result;
  assign dp.Alu_zero = (alu_result == '0);
  assign dp.Dm_rdata = dm_rdata_q;
  assign dp.W_data   = w_data;

endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath
// Drives processor_datapath through directed control sequences (reset, load,
// store, add/sub wrap, register read-during-write, reset mid-load) followed by
// random control words. Each cycle's expected outputs come from an array-based
// reference model and are queued; a monitor on the falling edge compares them.
module tb_processor_datapath;
  localparam int DATA_W = 16;
  localparam int RF_AW  = 4;
  localparam int DM_AW  = 8;

  typedef struct {
    int d_addr; bit d_wr; bit rf_s; bit w_en;
    int w_addr; int ra; int rb; int op;
  } ctrl_t;

  typedef struct {
    int ra; int rb; int alu; bit zero;
    int dm; int wdata; bit dm_known;
  } exp_t;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;

  processor_datapath_if #(.DATA_W(DATA_W), .RF_AW(RF_AW), .DM_AW(DM_AW)) dp_bus ();

  processor_datapath #(.DATA_W(DATA_W), .RF_AW(RF_AW), .DM_AW(DM_AW)) dut (
    .Clk(Clk),
    .ResetN(ResetN),
    .dp(dp_bus)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  int    rRef [16];
  int    mRef [256];
  bit    mKnown [256];
  int    dmr;
  bit    dmrKnown;
  ctrl_t cur;
  exp_t  expQ [$];
  int    compared = 0;
  int    mismatched = 0;
  bit    stimDone = 0;

  function automatic int aluModel(input int op, input int a, input int b);
    case (op)
      0:       return 0;
      1:       return (a + b) % 65536;
      2:       return (a - b + 65536) % 65536;
      3:       return a;
      4:       return a ^ b;
      5:       return a | b;
      6:       return a & b;
      default: return (a + 1) % 65536;
    endcase
  endfunction

  function automatic exp_t expOf(input ctrl_t c);
    exp_t e;
    e.ra       = rRef[c.ra];
    e.rb       = rRef[c.rb];
    e.alu      = aluModel(c.op, e.ra, e.rb);
    e.zero     = (e.alu == 0);
    e.dm       = dmr;
    e.dm_known = dmrKnown;
    e.wdata    = c.rf_s ? dmr : e.alu;
    return e;
  endfunction

  function automatic ctrl_t mk(input int d_addr, input bit d_wr, input bit rf_s,
                               input bit w_en, input int w_addr, input int ra,
                               input int rb, input int op);
    ctrl_t c;
    c.d_addr = d_addr; c.d_wr = d_wr; c.rf_s = rf_s; c.w_en = w_en;
    c.w_addr = w_addr; c.ra = ra; c.rb = rb; c.op = op;
    return c;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 16; i++) rRef[i] = 0;
    dmr = 0;
    dmrKnown = 1;
  endtask

  // Effect of one rising edge outside reset, applied to the model.
  task automatic updateModel(input ctrl_t c);
    int a;
    int w;
    int newDmr;
    bit newKnown;
    a        = rRef[c.ra];
    w        = c.rf_s ? dmr : aluModel(c.op, rRef[c.ra], rRef[c.rb]);
    newDmr   = mRef[c.d_addr];
    newKnown = mKnown[c.d_addr];
    if (c.w_en) rRef[c.w_addr] = w;
    if (c.d_wr) begin
      mRef[c.d_addr]   = a;
      mKnown[c.d_addr] = 1;
    end
    dmr      = newDmr;
    dmrKnown = newKnown;
  endtask

  task automatic drive(input ctrl_t c);
    dp_bus.D_addr     = DM_AW'(c.d_addr);
    dp_bus.D_wr       = c.d_wr;
    dp_bus.RF_s       = c.rf_s;
    dp_bus.RF_W_en    = c.w_en;
    dp_bus.RF_W_addr  = RF_AW'(c.w_addr);
    dp_bus.RF_Ra_addr = RF_AW'(c.ra);
    dp_bus.RF_Rb_addr = RF_AW'(c.rb);
    dp_bus.Alu_s0     = 3'(c.op);
  endtask

  // Called just after a rising edge: present one control word for one cycle.
  task automatic applyStimulus(input ctrl_t c);
    cur = c;
    drive(c);
    expQ.push_back(expOf(c));
    @(posedge Clk);
    #1;
    updateModel(c);
  endtask

  // Assert reset mid-cycle with the current controls still applied; outputs
  // must clear before the next clock edge. Released just after a rising edge.
  task automatic applyReset(input int holdCycles);
    #2;
    ResetN = 1'b0;
    clearModel();
    expQ.push_back(expOf(cur));
    @(posedge Clk);
    #1;
    for (int i = 1; i < holdCycles; i++) begin
      expQ.push_back(expOf(cur));
      @(posedge Clk);
      #1;
    end
    ResetN = 1'b1;
  endtask

  // Build a constant in register r by clearing it, then double-and-increment per bit.
  task automatic loadConst(input int r, input int value);
    applyStimulus(mk(0, 0, 0, 1, r, r, r, 0));
    for (int b = 15; b >= 0; b--) begin
      applyStimulus(mk(0, 0, 0, 1, r, r, r, 1));
      if (value[b]) applyStimulus(mk(0, 0, 0, 1, r, r, r, 7));
    end
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input int expv);
    logic [DATA_W-1:0] e;
    e = DATA_W'(expv);
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, e, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("Ra_data", dp_bus.Ra_data, e.ra);
        checkOutput("Rb_data", dp_bus.Rb_data, e.rb);
        checkOutput("Alu_out", dp_bus.Alu_out, e.alu);
        checkOutput("Alu_zero", DATA_W'(dp_bus.Alu_zero), int'(e.zero));
        if (e.dm_known) begin
          checkOutput("Dm_rdata", dp_bus.Dm_rdata, e.dm);
          checkOutput("W_data", dp_bus.W_data, e.wdata);
        end
      end
    end
  end

  initial begin
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(cur);
    clearModel();
    for (int i = 0; i < 256; i++) begin
      mRef[i] = 0;
      mKnown[i] = 0;
    end
    @(posedge Clk);
    #1;

    $display("[TB] reset and register sweep");
    applyReset(2);
    for (int i = 0; i < 16; i++) applyStimulus(mk(0, 0, 0, 0, 0, i, 15 - i, 1));

    $display("[TB] initialise data memory through R0");
    for (int i = 0; i < 256; i++) applyStimulus(mk(i, 1, 0, 0, 0, 0, 0, 0));

    $display("[TB] load sequence");
    loadConst(9, 16'h00F3);
    applyStimulus(mk(8'h1A, 1, 0, 0, 0, 9, 9, 3));
    applyStimulus(mk(8'h1A, 0, 1, 0, 3, 3, 3, 3));
    applyStimulus(mk(8'h1A, 0, 1, 1, 3, 3, 3, 3));
    applyStimulus(mk(8'h1A, 0, 0, 0, 0, 3, 9, 2));

    $display("[TB] add/sub wrap");
    loadConst(1, 16'hFFFF);
    loadConst(2, 16'h0002);
    applyStimulus(mk(0, 0, 0, 1, 4, 1, 2, 1));
    applyStimulus(mk(0, 0, 0, 1, 5, 2, 1, 2));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 1, 2));
    applyStimulus(mk(0, 0, 0, 0, 0, 4, 5, 3));

    $display("[TB] store with read-during-write");
    loadConst(6, 16'hBEEF);
    applyStimulus(mk(8'hFF, 0, 0, 0, 0, 6, 6, 3));
    applyStimulus(mk(8'hFF, 1, 0, 0, 0, 6, 6, 3));
    applyStimulus(mk(8'hFF, 0, 0, 0, 0, 6, 6, 3));
    applyStimulus(mk(8'hFF, 0, 1, 0, 0, 6, 6, 3));

    $display("[TB] register read-during-write");
    loadConst(7, 16'h0010);
    applyStimulus(mk(0, 0, 0, 1, 7, 7, 7, 7));
    applyStimulus(mk(0, 0, 0, 0, 0, 7, 7, 3));

    $display("[TB] reset between Load_A and Load_B");
    loadConst(10, 16'h1234);
    applyStimulus(mk(8'h1A, 0, 1, 0, 10, 10, 10, 3));
    cur = mk(8'h1A, 1, 1, 1, 10, 10, 10, 3);
    drive(cur);
    applyReset(1);
    applyStimulus(mk(8'h1A, 0, 1, 1, 10, 10, 10, 3));
    applyStimulus(mk(8'h1A, 0, 0, 0, 0, 10, 3, 1));

    $display("[TB] random control words");
    for (int n = 0; n < 400; n++) begin
      ctrl_t c;
      c = mk(int'($urandom_range(255)), bit'($urandom_range(1)), bit'($urandom_range(1)),
             bit'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(15)), int'($urandom_range(7)));
      if ($urandom_range(49) == 0) begin
        cur = c;
        drive(c);
        applyReset(1);
      end else begin
        applyStimulus(c);
      end
    end

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge Clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
    end
    stimDone = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard bound on run time in case the stimulus process ever stalls.
  initial begin
    #200000;
    if (!stimDone) begin
      $display("[TB] FAIL timeout: stimulus incomplete, expected done");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
